// File: rtl/ok_fifo_pkg.sv
// ok_fifo_pkg: shared geometry, types and pointer helpers for ok_fifo16x8
package ok_fifo_pkg;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW = 4;
    localparam int FIFO_DW = 8;
    localparam int FIFO_PW = FIFO_AW + 1;
    typedef logic [FIFO_PW-1:0] ptr_t;
    typedef logic [FIFO_DW-1:0] data_t;
    function automatic logic [FIFO_PW-1:0] ptr_count(input ptr_t w, input ptr_t r);
        return w - r;
    endfunction
    // Same slot with opposite wrap bits means the writer is one lap ahead.
    function automatic logic ptr_full(input ptr_t w, input ptr_t r);
        return (w[FIFO_AW-1:0] == r[FIFO_AW-1:0]) && (w[FIFO_AW] != r[FIFO_AW]);
    endfunction
endpackage

// File: rtl/ok_fifo16x8_dram.sv
// okDRAM16X8D: 16x8 dual-port distributed RAM, synchronous write, asynchronous read
module okDRAM16X8D
    import ok_fifo_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [FIFO_AW-1:0] waddr,
    input  logic [FIFO_DW-1:0] wdata,
    input  logic [FIFO_AW-1:0] raddr,
    output logic [FIFO_DW-1:0] rdata
);
    data_t mem [FIFO_DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/ok_fifo16x8.sv
// ok_fifo16x8: 16x8 synchronous FIFO with registered flags and data output
// Define OK_FIFO_FWFT_EN for first-word-fall-through; undefined gives standard read latency.
module ok_fifo16x8
    import ok_fifo_pkg::*;
#(
    parameter int AFULL_THRESH = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [FIFO_DW-1:0] din,
    input  logic               rd_en,
    output logic [FIFO_DW-1:0] dout,
    output logic               full,
    output logic               almost_full,
    output logic               empty,
    output logic [FIFO_PW-1:0] count,
    output logic               overflow,
    output logic               underflow
);
    localparam logic [FIFO_PW-1:0] AF_LEVEL = FIFO_PW'(AFULL_THRESH);
    ptr_t wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    data_t ram_q;
    logic wr_ok, ram_rd;
    logic [FIFO_PW-1:0] count_nxt;
    okDRAM16X8D u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr[FIFO_AW-1:0]),
        .wdata (din),
        .raddr (rd_ptr[FIFO_AW-1:0]),
        .rdata (ram_q)
    );
    assign wr_ok  = wr_en && !full;
    assign wr_nxt = wr_ptr + FIFO_PW'(wr_ok);
    assign rd_nxt = rd_ptr + FIFO_PW'(ram_rd);
`ifdef OK_FIFO_FWFT_EN
    logic valid, valid_nxt, ram_avail;
    // ram_avail sees writes one edge late, giving the N+2 fall-through timing
    assign ram_rd    = ram_avail && (!valid || rd_en);
    assign valid_nxt = ram_rd || (valid && !rd_en);
    assign count_nxt = ptr_count(wr_nxt, rd_nxt) + FIFO_PW'(valid_nxt);
    assign empty     = !valid;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid     <= 1'b0;
            ram_avail <= 1'b0;
        end else begin
            valid     <= valid_nxt;
            ram_avail <= wr_ptr != rd_nxt;
        end
`else
    assign ram_rd    = rd_en && !empty;
    assign count_nxt = ptr_count(wr_nxt, rd_nxt);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) empty <= 1'b1;
        else empty <= wr_nxt == rd_nxt;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            dout        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wr_ptr      <= wr_nxt;
            rd_ptr      <= rd_nxt;
            dout        <= ram_rd ? ram_q : dout;
            full        <= ptr_full(wr_nxt, rd_nxt);
            almost_full <= count_nxt >= AF_LEVEL;
            count       <= count_nxt;
            overflow    <= wr_en && full;
            underflow   <= rd_en && empty;
        end
endmodule

// File: tb/tb_ok_fifo16x8.sv
// tb_ok_fifo16x8: directed self-checking bench for ok_fifo16x8 in standard read mode
module tb_ok_fifo16x8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_en = 1'b0;
    logic rd_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic full, almost_full, empty, overflow, underflow;
    logic [4:0] count;
    int checks = 0;
    int failures = 0;

    ok_fifo16x8 #(.AFULL_THRESH(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .din         (din),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] d;
        logic [17:0] exp;
    } vec_t;

    // packed state: {dout, full, almost_full, empty, count, overflow, underflow}
    function automatic logic [17:0] pk(input logic [7:0] d, input int f, input int af,
                                       input int e, input int c, input int o, input int u);
        return {d, 1'(f), 1'(af), 1'(e), 5'(c), 1'(o), 1'(u)};
    endfunction

    task automatic chk(input string name, input logic [17:0] e);
        logic [17:0] a;
        a = {dout, full, almost_full, empty, count, overflow, underflow};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got dout=%h full=%b af=%b empty=%b count=%0d ovf=%b udf=%b exp dout=%h full=%b af=%b empty=%b count=%0d ovf=%b udf=%b",
                     name, a[17:10], a[9], a[8], a[7], a[6:2], a[1], a[0],
                     e[17:10], e[9], e[8], e[7], e[6:2], e[1], e[0]);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        din = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        tbl[0] = '{1'b0, 1'b1, 8'h00, pk(8'h00, 0, 0, 1, 0, 0, 1)};
        tbl[1] = '{1'b1, 1'b1, 8'h33, pk(8'h00, 0, 0, 0, 1, 0, 1)};
        tbl[2] = '{1'b1, 1'b0, 8'h44, pk(8'h00, 0, 0, 0, 2, 0, 0)};
        tbl[3] = '{1'b0, 1'b1, 8'h00, pk(8'h33, 0, 0, 0, 1, 0, 0)};
        tbl[4] = '{1'b1, 1'b1, 8'h55, pk(8'h44, 0, 0, 0, 1, 0, 0)};
        tbl[5] = '{1'b0, 1'b1, 8'h00, pk(8'h55, 0, 0, 1, 0, 0, 0)};
        tbl[6] = '{1'b0, 1'b0, 8'h00, pk(8'h55, 0, 0, 1, 0, 0, 0)};
        tbl[7] = '{1'b0, 1'b1, 8'h00, pk(8'h55, 0, 0, 1, 0, 0, 1)};
        tbl[8] = '{1'b0, 1'b0, 8'h00, pk(8'h55, 0, 0, 1, 0, 0, 0)};

        repeat (2) @(posedge clk);
        #1;
        chk("reset", pk(8'h00, 0, 0, 1, 0, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].w, tbl[i].r, tbl[i].d);
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h11 + i));
            chk($sformatf("fill%0d", i), pk(8'h55, i == 15, i + 1 >= 12, 0, i + 1, 0, 0));
        end
        cyc(1'b1, 1'b0, 8'hAA);
        chk("overflow", pk(8'h55, 1, 1, 0, 16, 1, 0));
        cyc(1'b0, 1'b0, 8'h00);
        chk("overflow_clear", pk(8'h55, 1, 1, 0, 16, 0, 0));

        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk($sformatf("read%0d", i), pk(8'(8'h11 + i), 0, 15 - i >= 12, i == 15, 15 - i, 0, 0));
        end
        cyc(1'b0, 1'b1, 8'h00);
        chk("underflow", pk(8'h20, 0, 0, 1, 0, 0, 1));
        cyc(1'b0, 1'b0, 8'h00);
        chk("underflow_clear", pk(8'h20, 0, 0, 1, 0, 0, 0));

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h60 + i));
            chk($sformatf("refill%0d", i), pk(8'h20, i == 15, i + 1 >= 12, 0, i + 1, 0, 0));
        end
        cyc(1'b1, 1'b1, 8'hBB);
        chk("full_wr_rd", pk(8'h60, 0, 1, 0, 15, 1, 0));
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk($sformatf("redrain%0d", i), pk(8'(8'h61 + i), 0, 14 - i >= 12, i == 14, 14 - i, 0, 0));
        end

        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h80 + i));
            chk($sformatf("pre%0d", i), pk(8'h6F, 0, 0, 0, i + 1, 0, 0));
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, 8'(8'h88 + i));
            chk($sformatf("stream%0d", i), pk(8'(8'h80 + i), 0, 0, 0, 8, 0, 0));
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk($sformatf("post%0d", i), pk(8'(8'hA8 + i), 0, 0, i == 7, 7 - i, 0, 0));
        end

        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 8'(8'hC0 + i));
            chk($sformatf("mid%0d", i), pk(8'hAF, 0, 0, 0, i + 1, 0, 0));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", pk(8'h00, 0, 0, 1, 0, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 1'b0, 8'h5A);
        chk("post_reset_wr", pk(8'h00, 0, 0, 0, 1, 0, 0));
        cyc(1'b0, 1'b1, 8'h00);
        chk("post_reset_rd", pk(8'h5A, 0, 0, 1, 0, 0, 0));
        cyc(1'b0, 1'b1, 8'h00);
        chk("post_reset_stale", pk(8'h5A, 0, 0, 1, 0, 0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
